sync_strobe_capture: RTL and testbench
======================================

// Module: sync_strobe_capture
// PURPOSE
//  Parametrised input front end for bench-I/O designs. Synchronises DATA_W async data lines
//  and STROBE_N async strobes, detects strobe rising edges, and queues {mask,data} samples in
//  a FIFO drained over valid/ready. Sits between the pins and user logic; level taps feed the ILA.
// PARAMETERS
//  DATA_W       4  width of data_async / out_data
//  STROBE_N     2  number of strobe channels (1..8)
//  SYNC_STAGES  2  synchroniser flops per bit (>=2)
//  DEPTH        4  FIFO entries; power of 2, >=2
//  FILTER_CYCLES 3 glitch-filter stability length in cycles (used only with STROBE_FILTER_EN)
//  CNT_W        8  drop-counter width
// PORTS
//  clk           in   1                 system clock
//  rst           in   1                 synchronous reset, active-high
//  data_async    in   DATA_W            async data pins
//  strobe_async  in   STROBE_N          async strobe pins
//  data_sync     out  DATA_W            synchronised data level (ILA tap)
//  strobe_sync   out  STROBE_N          synchronised (filtered) strobe level (ILA tap)
//  out_valid     out  1                 FIFO head valid
//  out_ready     in   1                 consumer accepts head
//  out_data      out  DATA_W            head data
//  out_mask      out  STROBE_N          head: channels that rose in that sample
//  level         out  $clog2(DEPTH)+1   FIFO occupancy
//  ovf_clr       in   1                 clear overflow and drop_cnt
//  overflow      out  1                 sticky: a sample was dropped
//  drop_cnt      out  CNT_W             dropped samples, saturating
// BEHAVIOUR
//  - One clock domain (clk); rst synchronous, active-high. Reset clears sync chains,
//    edge-history register, FIFO pointers, overflow and drop_cnt. All outputs 0 the cycle after rst.
//  - Data and strobes use identical SYNC_STAGES chains, so data/strobe skew is preserved.
//  - rise[i] = s[i] & ~prev[i]; prev <= s each cycle. After reset prev=0: a pin held high
//    through reset yields one edge once its high value reaches the chain output.
//  - Push when |rise; entry = {rise, data at same stage}. Simultaneous rises give one entry, mask has multiple bits.
//  - Latency: a pin change sampled at clock edge k is at chain output after edge k+SYNC_STAGES-1,
//    written at edge k+SYNC_STAGES; out_valid=1 after that edge. out_data/out_mask are show-ahead (no read latency).
//  - Pop when out_valid & out_ready. out_valid deasserts the cycle after the last entry pops.
//  - Full: push accepted if level<DEPTH or a pop occurs the same cycle (level unchanged).
//    Otherwise the sample is dropped: overflow<=1, drop_cnt saturates at 2^CNT_W-1. FIFO contents untouched.
//  - Empty: out_ready ignored. Push and pop never happen together when empty (out_valid=0).
//  - ovf_clr clears overflow/drop_cnt. A drop in the same cycle wins: overflow=1, drop_cnt=1.
//  - Pointers wrap modulo DEPTH. level uses an extra MSB to tell full from empty.
//  - rst mid-operation discards queued entries; no partial entry is ever presented.
// CONFIGURATION
//  STROBE_FILTER_EN defined: per-channel counter (clog2(FILTER_CYCLES+1) bits). The filtered
//    strobe takes the new chain value only after FILTER_CYCLES consecutive cycles at that value.
//    Edge detection uses the filtered strobe. Adds FILTER_CYCLES cycles latency. Data is not
//    delayed and is captured when the filtered edge fires. Counters reset to 0; filtered level resets to 0.
//  Not defined: filtered strobe == chain output; FILTER_CYCLES unused; no counters generated.
// STRUCTURE
//  - Shared package sync_capture_pkg: clog2 function, entry field offsets
//    (MASK_LSB=DATA_W), and DROP_SAT constant.
//  - Sub-module sync_fifo (WIDTH=DATA_W+STROBE_N, DEPTH): register-array FIFO,
//    show-ahead read, level output, push_ok output. Edge logic, filter and drop counters stay here.
// TESTING (DATA_W=4, STROBE_N=2, SYNC_STAGES=2, DEPTH=4)
//  1 rst, data=4'hA, strobe[0] 0->1 -> out_valid=1 exactly 2 edges after first sampling;
//    out_data=A, out_mask=01. ready=1 -> level=0 next cycle.
//  2 both strobes rise same cycle, data=5 -> single entry, out_mask=11, level=1.
//  3 ready=0, 5 edges with data 1..5 -> level=4, overflow=1, drop_cnt=1; drain gives 1,2,3,4 in order.
//  4 full, ready=1 and a new edge same cycle -> accepted, level=4, drop_cnt unchanged; tail=new data.
//  5 3 entries queued, rst=1 one cycle -> next cycle out_valid=0, level=0, overflow=0, drop_cnt=0.
//  6 STROBE_FILTER_EN, FILTER_CYCLES=3: 2-cycle pulse -> no entry; 4-cycle pulse -> one entry.
//    Without the macro, the 2-cycle pulse -> one entry.

Source files
------------

// File: rtl/sync_capture_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_capture_pkg                                                         |
// | Shared helpers for the strobe-capture front end: clog2, entry layout,    |
// | drop-counter saturation value.                                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sync_capture_pkg;

  // An entry is {mask, data}; data sits at bit 0 and the mask starts at DATA_W.
  localparam int DATA_LSB = 0;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  function automatic int mask_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic longint unsigned drop_sat(input int cnt_w);
    return (longint'(1) << cnt_w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo                                                                |
// | Register-array FIFO with show-ahead head, occupancy and push_ok.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sync_fifo
  import sync_capture_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_push_data,
  input  logic                    i_pop,
  output logic                    o_valid,
  output logic [WIDTH-1:0]        o_head,
  output logic [clog2(DEPTH):0]   o_level,
  output logic                    o_push_ok
);

  localparam int c_AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic [c_AW:0]    w_level;
  logic             w_pop;
  logic             w_wr_en;

  // Pointers carry one extra MSB; with DEPTH a power of 2 the level MSB flags full.
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign o_valid   = (w_level != '0);
  assign w_pop     = i_pop & o_valid;
  assign o_push_ok = ~w_level[c_AW] | w_pop;
  assign w_wr_en   = i_push & o_push_ok;
  assign o_level   = w_level;
  assign o_head    = o_valid ? r_mem[r_rd_ptr[c_AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sync_strobe_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_strobe_capture                                                      |
// | Synchronises async data/strobes, queues {mask,data} on strobe rises.     |
// | Optional glitch filter on strobes: define STROBE_FILTER_EN.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sync_strobe_capture
  import sync_capture_pkg::*;
#(
  parameter int DATA_W        = 4,
  parameter int STROBE_N      = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int DEPTH         = 4,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      data_async,
  input  logic [STROBE_N-1:0]    strobe_async,
  output logic [DATA_W-1:0]      data_sync,
  output logic [STROBE_N-1:0]    strobe_sync,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [STROBE_N-1:0]    out_mask,
  output logic [clog2(DEPTH):0]  level,
  input  logic                   ovf_clr,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int               c_ENTRY_W  = DATA_W + STROBE_N;
  localparam int               c_MASK_LSB = mask_lsb(DATA_W);
  localparam logic [CNT_W-1:0] c_DROP_SAT = CNT_W'(drop_sat(CNT_W));

  if (STROBE_N < 1 || STROBE_N > 8 || SYNC_STAGES < 2 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || FILTER_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("sync_strobe_capture: invalid parameter set");
  end

  logic [SYNC_STAGES-1:0][DATA_W-1:0]   r_data_chain;
  logic [SYNC_STAGES-1:0][STROBE_N-1:0] r_strobe_chain;
  logic [DATA_W-1:0]    w_data_s;
  logic [STROBE_N-1:0]  w_strobe_raw;
  logic [STROBE_N-1:0]  w_strobe_filt;
  logic [STROBE_N-1:0]  r_prev;
  logic [STROBE_N-1:0]  w_rise;
  logic                 w_push;
  logic                 w_push_ok;
  logic                 w_drop;
  logic [c_ENTRY_W-1:0] w_entry;
  logic [c_ENTRY_W-1:0] w_head;
  logic                 r_overflow;
  logic [CNT_W-1:0]     r_drop_cnt;

  // Identical chain depth for data and strobes keeps their relative skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_chain   <= '0;
      r_strobe_chain <= '0;
    end else begin
      r_data_chain   <= {r_data_chain[SYNC_STAGES-2:0], data_async};
      r_strobe_chain <= {r_strobe_chain[SYNC_STAGES-2:0], strobe_async};
    end
  end

  assign w_data_s     = r_data_chain[SYNC_STAGES-1];
  assign w_strobe_raw = r_strobe_chain[SYNC_STAGES-1];

`ifdef STROBE_FILTER_EN
  localparam int                  c_FCNT_W    = clog2(FILTER_CYCLES + 1);
  localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(FILTER_CYCLES - 1);

  for (genvar g = 0; g < STROBE_N; g++) begin : g_filter
    logic [c_FCNT_W-1:0] r_cnt;
    logic                r_filt;

    // Adopt the chain value only once it has differed for FILTER_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt  <= '0;
        r_filt <= 1'b0;
      end else if (w_strobe_raw[g] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == c_FCNT_LAST) begin
        r_cnt  <= '0;
        r_filt <= w_strobe_raw[g];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_strobe_filt[g] = r_filt;
  end
`else
  assign w_strobe_filt = w_strobe_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_strobe_filt;
    end
  end

  assign w_rise = w_strobe_filt & ~r_prev;
  assign w_push = |w_rise;

  always_comb begin
    w_entry = '0;
    w_entry[DATA_LSB +: DATA_W]     = w_data_s;
    w_entry[c_MASK_LSB +: STROBE_N] = w_rise;
  end

  sync_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_entry),
    .i_pop       (out_ready),
    .o_valid     (out_valid),
    .o_head      (w_head),
    .o_level     (level),
    .o_push_ok   (w_push_ok)
  );

  // A drop in the same cycle as ovf_clr restarts the count at one.
  assign w_drop = w_push & ~w_push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (ovf_clr) begin
        r_drop_cnt <= CNT_W'(1);
      end else if (r_drop_cnt != c_DROP_SAT) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign data_sync   = w_data_s;
  assign strobe_sync = w_strobe_filt;
  assign out_data    = w_head[DATA_LSB +: DATA_W];
  assign out_mask    = w_head[c_MASK_LSB +: STROBE_N];
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sync_strobe_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sync_strobe_capture                                                   |
// | Directed self-checking bench for sync_strobe_capture (4/2/2/4 config).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sync_strobe_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] data_async = '0;
  logic [1:0] strobe_async = '0;
  logic [3:0] data_sync;
  logic [1:0] strobe_sync;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [1:0] out_mask;
  logic [2:0] level;
  logic       ovf_clr = 1'b0;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_strobe_capture #(
    .DATA_W (4), .STROBE_N (2), .SYNC_STAGES (2),
    .DEPTH (4), .FILTER_CYCLES (3), .CNT_W (8)
  ) dut (
    .clk (clk), .rst (rst),
    .data_async (data_async), .strobe_async (strobe_async),
    .data_sync (data_sync), .strobe_sync (strobe_sync),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_data (out_data), .out_mask (out_mask),
    .level (level), .ovf_clr (ovf_clr),
    .overflow (overflow), .drop_cnt (drop_cnt)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] d, input logic [1:0] m);
    data_async   = d;
    strobe_async = m;
    tick();
    strobe_async = 2'b00;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if ({out_data, out_mask, overflow, drop_cnt} !== 15'd0) begin failures++; $display("FAIL reset_outs got=%h/%b/%b/%0d exp=0", out_data, out_mask, overflow, drop_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_edge;
    data_async   = 4'hA;
    strobe_async = 2'b01;
    tick(2);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%b exp=0", out_valid); end
    checks++; if (data_sync !== 4'hA) begin failures++; $display("FAIL data_sync got=%h exp=a", data_sync); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 4'hA || out_mask !== 2'b01) begin failures++; $display("FAIL single_entry got=%h/%b exp=a/01", out_data, out_mask); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL single_pop got=%0d/%b exp=0/0", level, out_valid); end
    strobe_async = 2'b00;
    tick(3);
  endtask

  task automatic test_dual_edge;
    data_async   = 4'h5;
    strobe_async = 2'b11;
    tick(5);
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL dual_level got=%0d exp=1", level); end
    checks++; if (out_data !== 4'h5 || out_mask !== 2'b11) begin failures++; $display("FAIL dual_entry got=%h/%b exp=5/11", out_data, out_mask); end
    strobe_async = 2'b00;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick(3);
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 5; i++) pulse(4'(i), 2'b01);
    tick(3);
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", level); end
    checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin failures++; $display("FAIL ovf_flag got=%b/%0d exp=1/1", overflow, drop_cnt); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 4'(i)) begin failures++; $display("FAIL drain_order got=%b/%h exp=1/%h", out_valid, out_data, 4'(i)); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL ovf_clear got=%b/%0d exp=0/0", overflow, drop_cnt); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 6; i <= 9; i++) pulse(4'(i), 2'b01);
    tick(3);
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", level); end
    pulse(4'hB, 2'b01);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (level !== 3'd4 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin failures++; $display("FAIL full_swap got=%0d/%0d/%b exp=4/0/0", level, drop_cnt, overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_d;
      exp_d = (i == 3) ? 4'hB : 4'(7 + i);
      checks++; if (out_data !== exp_d) begin failures++; $display("FAIL full_tail got=%h exp=%h", out_data, exp_d); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clr_race_and_reset;
    for (int i = 1; i <= 5; i++) pulse(4'(i), 2'b01);
    tick(3);
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL race_pre got=%0d exp=1", drop_cnt); end
    pulse(4'h6, 2'b01);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin failures++; $display("FAIL clr_race got=%b/%0d exp=1/1", overflow, drop_cnt); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL pre_rst_level got=%0d exp=3", level); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL midrst_fifo got=%b/%0d exp=0/0", out_valid, level); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0 || out_data !== 4'h0) begin failures++; $display("FAIL midrst_flags got=%b/%0d/%h exp=0/0/0", overflow, drop_cnt, out_data); end
    tick(2);
  endtask

  task automatic test_filter;
    logic [2:0] exp_lvl;
`ifdef STROBE_FILTER_EN
    exp_lvl = 3'd0;
`else
    exp_lvl = 3'd1;
`endif
    data_async   = 4'h3;
    strobe_async = 2'b10;
    tick(2);
    strobe_async = 2'b00;
    tick(10);
    checks++; if (level !== exp_lvl) begin failures++; $display("FAIL short_pulse got=%0d exp=%0d", level, exp_lvl); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    data_async   = 4'hC;
    strobe_async = 2'b10;
    tick(4);
    strobe_async = 2'b00;
    tick(10);
    checks++; if (level !== 3'd1 || out_data !== 4'hC || out_mask !== 2'b10) begin failures++; $display("FAIL long_pulse got=%0d/%h/%b exp=1/c/10", level, out_data, out_mask); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_dual_edge();
    test_overflow();
    test_full_push_pop();
    test_clr_race_and_reset();
    test_filter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
